// File: rtl/ana_trigger_unit.sv
// Programmable trigger generator for the signal analyzer: masked compare,
// compare-edge or masked-change events, with event count, post-match delay and hold.
module ana_trigger_unit #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] probe,
  input  logic                  arm,
  input  logic [DATA_WIDTH-1:0] cfg_value,
  input  logic [DATA_WIDTH-1:0] cfg_mask,
  input  logic [1:0]            cfg_mode,
  input  logic [CNT_WIDTH-1:0]  cfg_count,
  input  logic [CNT_WIDTH-1:0]  cfg_delay,
  input  logic [CNT_WIDTH-1:0]  cfg_hold,
  output logic                  trigger,
  output logic                  armed,
  output logic [2:0]            state,
  output logic [CNT_WIDTH-1:0]  event_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_DELAY = 3'd2,
    S_FIRE  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic                    arm_q, arm_low_seen_q;
  logic                    match_q;
  logic [DATA_WIDTH-1:0]   probe_q;
  logic                    trigger_q, armed_q;
  logic [CNT_WIDTH-1:0]    event_cnt_q, event_cnt_d;
  logic [CNT_WIDTH-1:0]    delay_cnt_q, delay_cnt_d;
  logic [CNT_WIDTH-1:0]    hold_cnt_q, hold_cnt_d;
  logic [DATA_WIDTH-1:0]   cfg_value_q, cfg_mask_q;
  logic [1:0]              cfg_mode_q;
  logic [CNT_WIDTH-1:0]    cfg_count_q, cfg_delay_q, cfg_hold_q;

  logic                    arm_rise, latch_cfg, match, evt;
  logic [DATA_WIDTH-1:0]   cur_value, cur_mask;
  logic [CNT_WIDTH-1:0]    count_eff, event_cnt_inc;

  // arm held high through reset must fall once before a rise is accepted.
  assign arm_rise = arm & ~arm_q & arm_low_seen_q;

  // While idle the live config is compared so match_q is valid on the first armed cycle.
  assign cur_value = (state_q == S_IDLE) ? cfg_value : cfg_value_q;
  assign cur_mask  = (state_q == S_IDLE) ? cfg_mask  : cfg_mask_q;
  assign match     = ((probe ^ cur_value) & cur_mask) == '0;

  assign count_eff     = (cfg_count_q == '0) ? CNT_WIDTH'(1) : cfg_count_q;
  assign event_cnt_inc = (&event_cnt_q) ? event_cnt_q : event_cnt_q + CNT_WIDTH'(1);

  always_comb begin
    case (cfg_mode_q)
      2'b00:   evt = match;
      2'b01:   evt = match & ~match_q;
      2'b10:   evt = |((probe ^ probe_q) & cfg_mask_q);
      default: evt = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d     = state_q;
    event_cnt_d = event_cnt_q;
    delay_cnt_d = delay_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    latch_cfg   = 1'b0;
    if (!arm) begin
      state_d     = S_IDLE;
      event_cnt_d = '0;
      delay_cnt_d = '0;
      hold_cnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          event_cnt_d = '0;
          delay_cnt_d = '0;
          hold_cnt_d  = '0;
          if (arm_rise) begin
            state_d   = S_ARMED;
            latch_cfg = 1'b1;
          end
        end
        S_ARMED: begin
          if (evt) begin
            event_cnt_d = event_cnt_inc;
            if (event_cnt_inc >= count_eff) begin
              if (cfg_delay_q == '0) begin
                state_d    = S_FIRE;
                hold_cnt_d = cfg_hold_q;
              end else begin
                state_d     = S_DELAY;
                delay_cnt_d = cfg_delay_q;
              end
            end
          end
        end
        S_DELAY: begin
          if (delay_cnt_q == CNT_WIDTH'(1)) begin
            state_d    = S_FIRE;
            hold_cnt_d = cfg_hold_q;
          end else begin
            delay_cnt_d = delay_cnt_q - CNT_WIDTH'(1);
          end
        end
        S_FIRE: begin
          if (hold_cnt_q == CNT_WIDTH'(1)) begin
            state_d = S_DONE;
          end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - CNT_WIDTH'(1);
          end
        end
        S_DONE:  ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q        <= S_IDLE;
      arm_q          <= 1'b0;
      arm_low_seen_q <= 1'b0;
      match_q        <= 1'b0;
      probe_q        <= '0;
      trigger_q      <= 1'b0;
      armed_q        <= 1'b0;
      event_cnt_q    <= '0;
      delay_cnt_q    <= '0;
      hold_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      arm_q          <= arm;
      arm_low_seen_q <= arm_low_seen_q | ~arm;
      match_q        <= match;
      probe_q        <= probe;
      trigger_q      <= (state_q == S_FIRE) & arm;
      armed_q        <= (state_d == S_ARMED) || (state_d == S_DELAY);
      event_cnt_q    <= event_cnt_d;
      delay_cnt_q    <= delay_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
    end
  end

  // NOTE: config registers have no reset; they are always loaded on arming before being read.
  always_ff @(posedge clk) begin
    if (latch_cfg) begin
      cfg_value_q <= cfg_value;
      cfg_mask_q  <= cfg_mask;
      cfg_mode_q  <= cfg_mode;
      cfg_count_q <= cfg_count;
      cfg_delay_q <= cfg_delay;
      cfg_hold_q  <= cfg_hold;
    end
  end

  assign trigger   = trigger_q;
  assign armed     = armed_q;
  assign state     = state_q;
  assign event_cnt = event_cnt_q;

endmodule

// File: tb/tb_ana_trigger_unit.sv
// Directed bench for ana_trigger_unit: vector tables plus hand-written multi-cycle sequences.
module tb_ana_trigger_unit;

  localparam logic [2:0] IDLE = 3'd0, ARMED = 3'd1, DELAY = 3'd2, FIRE = 3'd3, DONE = 3'd4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] probe, cfg_value, cfg_mask;
  logic        arm;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_count, cfg_delay, cfg_hold;
  logic        trigger, armed;
  logic [2:0]  state;
  logic [15:0] event_cnt;

  logic [7:0]  s_probe, s_value, s_mask;
  logic        s_arm;
  logic [1:0]  s_mode;
  logic [3:0]  s_count, s_delay, s_hold;
  logic        s_trigger, s_armed;
  logic [2:0]  s_state;
  logic [3:0]  s_event_cnt;

  ana_trigger_unit dut (
    .clk(clk), .rst(rst), .probe(probe), .arm(arm),
    .cfg_value(cfg_value), .cfg_mask(cfg_mask), .cfg_mode(cfg_mode),
    .cfg_count(cfg_count), .cfg_delay(cfg_delay), .cfg_hold(cfg_hold),
    .trigger(trigger), .armed(armed), .state(state), .event_cnt(event_cnt)
  );

  ana_trigger_unit #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_small (
    .clk(clk), .rst(rst), .probe(s_probe), .arm(s_arm),
    .cfg_value(s_value), .cfg_mask(s_mask), .cfg_mode(s_mode),
    .cfg_count(s_count), .cfg_delay(s_delay), .cfg_hold(s_hold),
    .trigger(s_trigger), .armed(s_armed), .state(s_state), .event_cnt(s_event_cnt)
  );

  typedef struct {
    logic        arm;
    logic [63:0] probe;
    logic        trig;
    logic        armd;
    logic [2:0]  st;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic t, input logic a,
                           input logic [2:0] s, input logic [15:0] c);
    check({tag, ".trigger"},   64'(trigger),   64'(t));
    check({tag, ".armed"},     64'(armed),     64'(a));
    check({tag, ".state"},     64'(state),     64'(s));
    check({tag, ".event_cnt"}, 64'(event_cnt), 64'(c));
  endtask

  function automatic vec_t mk(input logic a, input logic [63:0] p, input logic t,
                              input logic ad, input logic [2:0] s, input logic [15:0] c);
    vec_t v;
    v.arm = a; v.probe = p; v.trig = t; v.armd = ad; v.st = s; v.cnt = c;
    return v;
  endfunction

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      arm   = tbl[i].arm;
      probe = tbl[i].probe;
      tick();
      check_out($sformatf("%s[%0d]", tag, i), tbl[i].trig, tbl[i].armd, tbl[i].st, tbl[i].cnt);
    end
    tbl.delete();
  endtask

  initial begin
    int hits;
    rst = 1'b1; arm = 1'b0; probe = '0;
    cfg_value = '0; cfg_mask = '0; cfg_mode = 2'b00;
    cfg_count = 16'd1; cfg_delay = '0; cfg_hold = 16'd1;
    s_arm = 1'b0; s_probe = '0; s_value = '0; s_mask = '0; s_mode = 2'b00;
    s_count = 4'hF; s_delay = '0; s_hold = 4'd2;
    repeat (3) tick();
    check_out("reset", 1'b0, 1'b0, IDLE, 16'd0);
    check("reset.small_state", 64'(s_state), 64'(IDLE));
    rst = 1'b0;

    // Level match, count 1, delay 0, hold 4
    cfg_value = 64'h5A; cfg_mask = 64'hFF; cfg_mode = 2'b00;
    cfg_count = 16'd1; cfg_delay = 16'd0; cfg_hold = 16'd4;
    tbl.push_back(mk(1'b0, 64'h00, 1'b0, 1'b0, IDLE,  16'd0));
    tbl.push_back(mk(1'b1, 64'h00, 1'b0, 1'b1, ARMED, 16'd0));
    tbl.push_back(mk(1'b1, 64'h00, 1'b0, 1'b1, ARMED, 16'd0));
    tbl.push_back(mk(1'b1, 64'h5A, 1'b0, 1'b0, FIRE,  16'd1));
    tbl.push_back(mk(1'b1, 64'h5A, 1'b1, 1'b0, FIRE,  16'd1));
    tbl.push_back(mk(1'b1, 64'h5A, 1'b1, 1'b0, FIRE,  16'd1));
    tbl.push_back(mk(1'b1, 64'h5A, 1'b1, 1'b0, FIRE,  16'd1));
    tbl.push_back(mk(1'b1, 64'h5A, 1'b1, 1'b0, DONE,  16'd1));
    tbl.push_back(mk(1'b1, 64'h5A, 1'b0, 1'b0, DONE,  16'd1));
    tbl.push_back(mk(1'b0, 64'h5A, 1'b0, 1'b0, IDLE,  16'd0));
    run_table("level");

    // Masked change on bit 0 only; the arming-cycle change must not count
    cfg_mask = 64'h1; cfg_mode = 2'b10; cfg_count = 16'd2; cfg_delay = 16'd0; cfg_hold = 16'd2;
    tbl.push_back(mk(1'b0, 64'h0, 1'b0, 1'b0, IDLE,  16'd0));
    tbl.push_back(mk(1'b1, 64'h1, 1'b0, 1'b1, ARMED, 16'd0));
    tbl.push_back(mk(1'b1, 64'h3, 1'b0, 1'b1, ARMED, 16'd0));
    tbl.push_back(mk(1'b1, 64'h1, 1'b0, 1'b1, ARMED, 16'd0));
    tbl.push_back(mk(1'b1, 64'h3, 1'b0, 1'b1, ARMED, 16'd0));
    tbl.push_back(mk(1'b1, 64'h2, 1'b0, 1'b1, ARMED, 16'd1));
    tbl.push_back(mk(1'b1, 64'h2, 1'b0, 1'b1, ARMED, 16'd1));
    tbl.push_back(mk(1'b1, 64'h3, 1'b0, 1'b0, FIRE,  16'd2));
    tbl.push_back(mk(1'b1, 64'h3, 1'b1, 1'b0, FIRE,  16'd2));
    tbl.push_back(mk(1'b1, 64'h3, 1'b1, 1'b0, DONE,  16'd2));
    tbl.push_back(mk(1'b1, 64'h3, 1'b0, 1'b0, DONE,  16'd2));
    tbl.push_back(mk(1'b0, 64'h3, 1'b0, 1'b0, IDLE,  16'd0));
    run_table("change");

    // Rising edge, count 3, delay 2, hold 1; config altered after arming must be ignored
    cfg_value = 64'hAA; cfg_mask = 64'hFF; cfg_mode = 2'b01;
    cfg_count = 16'd3; cfg_delay = 16'd2; cfg_hold = 16'd1;
    probe = 64'h0; arm = 1'b0; tick();
    arm = 1'b1; tick();
    check("edge.armed_state", 64'(state), 64'(ARMED));
    cfg_value = 64'h0; cfg_mode = 2'b00; cfg_count = 16'd1;
    for (int k = 1; k <= 13; k++) begin
      probe = (((k - 1) / 2) % 2 == 0) ? 64'hAA : 64'h00;
      tick();
      check($sformatf("edge.trigger[%0d]", k), 64'(trigger), 64'(k == 12));
      if (k == 8)  check("edge.cnt_before_3rd", 64'(event_cnt), 64'd2);
      if (k == 9)  check("edge.cnt_3rd", 64'(event_cnt), 64'd3);
      if (k == 9)  check("edge.state_delay", 64'(state), 64'(DELAY));
      if (k == 12) check("edge.state_done", 64'(state), 64'(DONE));
    end
    arm = 1'b0; tick();
    check("edge.back_idle", 64'(state), 64'(IDLE));

    // Hold 0; arm dropped mid-DELAY
    cfg_value = '0; cfg_mask = '0; cfg_mode = 2'b00;
    cfg_count = 16'd1; cfg_delay = 16'd5; cfg_hold = 16'd0;
    arm = 1'b1; tick();
    check_out("abort.arm_with_match", 1'b0, 1'b1, ARMED, 16'd0);
    tick();
    check_out("abort.delay", 1'b0, 1'b1, DELAY, 16'd1);
    tick();
    arm = 1'b0; tick();
    check_out("abort.delay_drop", 1'b0, 1'b0, IDLE, 16'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("abort.quiet[%0d]", k), 64'({trigger, state}), 64'({1'b0, IDLE}));
    end

    // Hold 0; arm dropped mid-FIRE
    cfg_delay = 16'd0;
    arm = 1'b1; tick(); tick();
    check_out("abort.fire_entry", 1'b0, 1'b0, FIRE, 16'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("abort.hold0[%0d]", k), 64'({trigger, state}), 64'({1'b1, FIRE}));
    end
    arm = 1'b0; tick();
    check_out("abort.fire_drop", 1'b0, 1'b0, IDLE, 16'd0);

    // Reset while firing, with arm still held high
    arm = 1'b1; tick(); tick(); tick();
    check("rst.firing", 64'(trigger), 64'd1);
    rst = 1'b1; tick();
    check_out("rst.in_fire", 1'b0, 1'b0, IDLE, 16'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rst.no_rearm[%0d]", k), 64'(state), 64'(IDLE));
    end
    arm = 1'b0; tick();
    arm = 1'b1; tick();
    check("rst.rearm", 64'(state), 64'(ARMED));
    arm = 1'b0; tick();

    // Mode 11 never fires
    cfg_mode = 2'b11; cfg_hold = 16'd1;
    arm = 1'b1; tick();
    hits = 0;
    repeat (1000) begin
      probe = {$urandom, $urandom};
      tick();
      if (trigger) hits++;
    end
    check("never.trigger_count", 64'(hits), 64'd0);
    check_out("never.final", 1'b0, 1'b1, ARMED, 16'd0);
    arm = 1'b0; tick();

    // Saturation with a 4-bit counter and count 0xF
    s_arm = 1'b1; tick();
    check("sat.armed", 64'(s_state), 64'(ARMED));
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 14) check("sat.cnt14", 64'({s_state, s_event_cnt}), 64'({ARMED, 4'd14}));
      if (k == 15) check("sat.cnt15", 64'({s_state, s_event_cnt}), 64'({FIRE, 4'hF}));
    end
    tick();
    check("sat.trig_on", 64'({s_trigger, s_event_cnt}), 64'({1'b1, 4'hF}));
    tick();
    check("sat.trig_last", 64'({s_trigger, s_state}), 64'({1'b1, DONE}));
    tick();
    check("sat.hold_cnt", 64'({s_trigger, s_event_cnt}), 64'({1'b0, 4'hF}));
    s_arm = 1'b0; tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
